// File: rtl/endgame_banner.sv
// End-of-game banner: latches the winner on game_over, slides "P<n> WIN"
// down to start_y, blinks "WIN" for HOLD_FRAMES frames, then holds it solid
// until restart_btn is pressed.
// Glyphs are 5x7 cell bitmaps with 4x4-pixel cells (20x28 pixels), top-left
// anchored; the winner digit is drawn from seven-segment strokes on that grid.
module endgame_banner #(
    parameter int N_PLAYERS    = 2,
    parameter int CHAR_PITCH   = 31,
    parameter int SLIDE_STEP   = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic [3:0] who_win,
    input  logic       restart_btn,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       display_player,
    output logic       display_win,
    output logic       banner_active,
    output logic       restart_req
);

    localparam int GLYPH_W = 20;
    localparam int GLYPH_H = 28;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, SLIDE, SHOW, WAIT} state_t;
    typedef enum logic [2:0] {G_P, G_DIGIT, G_W, G_I, G_N} glyph_t;

    state_t          state;
    logic [9:0]      cur_y;
    logic [3:0]      winner;
    logic [3:0]      winner_in;
    logic [BW-1:0]   blink_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            visible;
    logic [10:0]     slide_nxt;
    logic [6:0]      seg;
    logic [11:0]     px, py, top, sx;
    logic            hit_p, hit_d, hit_w, hit_i, hit_n;

    assign slide_nxt = {1'b0, cur_y} + 11'(SLIDE_STEP);
    assign px  = {2'b00, x};
    assign py  = {2'b00, y};
    assign top = {2'b00, cur_y};
    assign sx  = {2'b00, start_x};

    // Out-of-range winner numbers fall back to player 1
    always_comb begin
        winner_in = 4'd1;
        if (who_win != 4'd0 && int'(who_win) <= N_PLAYERS)
            winner_in = who_win;
    end

    // Banner state machine: slide, blink/hold, wait for restart
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_y         <= '0;
            winner        <= 4'd1;
            blink_cnt     <= '0;
            hold_cnt      <= '0;
            visible       <= 1'b1;
            restart_req   <= 1'b0;
            banner_active <= 1'b0;
        end else begin
            restart_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_over) begin
                        winner        <= winner_in;
                        cur_y         <= '0;
                        state         <= SLIDE;
                        banner_active <= 1'b1;
                    end
                end
                SLIDE: begin
                    if (frame_tick) begin
                        if (slide_nxt >= {1'b0, start_y}) begin
                            cur_y     <= start_y;
                            state     <= SHOW;
                            blink_cnt <= '0;
                            hold_cnt  <= '0;
                            visible   <= 1'b1;
                        end else begin
                            cur_y <= slide_nxt[9:0];
                        end
                    end
                end
                SHOW: begin
                    // Counters compare against N-1 before incrementing, so the
                    // action lands on the N-th tick without an extra bit of width.
                    if (frame_tick) begin
                        if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                            state   <= WAIT;
                            visible <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                                blink_cnt <= '0;
                                visible   <= ~visible;
                            end else begin
                                blink_cnt <= blink_cnt + BW'(1);
                            end
                        end
                    end
                end
                WAIT: begin
                    visible <= 1'b1;
                    if (restart_btn) begin
                        restart_req   <= 1'b1;
                        state         <= IDLE;
                        banner_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Seven-segment pattern {g,f,e,d,c,b,a} of the latched winner
    always_comb begin
        case (winner)
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000110;
        endcase
    end

    // One 5-cell row of a glyph, bit 4 is the leftmost cell
    function automatic logic [4:0] glyph_row(input glyph_t g, input logic [2:0] r,
                                             input logic [6:0] s);
        logic [4:0] b;
        b = '0;
        case (g)
            G_P: case (r)
                3'd0, 3'd3: b = 5'b11110;
                3'd1, 3'd2: b = 5'b10001;
                default:    b = 5'b10000;
            endcase
            G_W: case (r)
                3'd0, 3'd1, 3'd2: b = 5'b10001;
                3'd3, 3'd4, 3'd5: b = 5'b10101;
                default:          b = 5'b01010;
            endcase
            G_I: case (r)
                3'd0, 3'd6: b = 5'b11111;
                default:    b = 5'b00100;
            endcase
            G_N: case (r)
                3'd1, 3'd2: b = 5'b11001;
                3'd3:       b = 5'b10101;
                3'd4, 3'd5: b = 5'b10011;
                default:    b = 5'b10001;
            endcase
            G_DIGIT: begin
                if (r == 3'd0 && s[0]) b = 5'b11111;
                if (r == 3'd3 && s[6]) b = 5'b11111;
                if (r == 3'd6 && s[3]) b = 5'b11111;
                if (r <= 3'd3) begin
                    if (s[5]) b[4] = 1'b1;
                    if (s[1]) b[0] = 1'b1;
                end
                if (r >= 3'd3) begin
                    if (s[4]) b[4] = 1'b1;
                    if (s[2]) b[0] = 1'b1;
                end
            end
            default: b = '0;
        endcase
        return b;
    endfunction

    // Pixel hit test for one glyph whose top-left corner is (gx, gy)
    function automatic logic glyph_hit(input glyph_t g, input logic [11:0] gx,
                                       input logic [11:0] gy, input logic [11:0] qx,
                                       input logic [11:0] qy, input logic [6:0] s);
        logic [11:0] dx, dy;
        logic [7:0]  bits;
        dx   = qx - gx;
        dy   = qy - gy;
        bits = {3'b000, glyph_row(g, dy[4:2], s)};
        return (qx >= gx) && (dx < 12'(GLYPH_W)) && (qy >= gy) && (dy < 12'(GLYPH_H))
               && bits[3'd4 - dx[4:2]];
    endfunction

    // Per-pixel glyph hits along the banner row
    always_comb begin
        hit_p = glyph_hit(G_P,     sx,                         top, px, py, seg);
        hit_d = glyph_hit(G_DIGIT, sx + 12'(CHAR_PITCH),       top, px, py, seg);
        hit_w = glyph_hit(G_W,     sx + 12'(3 * CHAR_PITCH),   top, px, py, seg);
        hit_i = glyph_hit(G_I,     sx + 12'(4 * CHAR_PITCH),   top, px, py, seg);
        hit_n = glyph_hit(G_N,     sx + 12'(5 * CHAR_PITCH),   top, px, py, seg);
    end

    // Mixer enables, blanked while idle; "WIN" also follows the blink phase
    always_comb begin
        display_player = (state != IDLE) && (hit_p || hit_d);
        display_win    = (state != IDLE) && visible && (hit_w || hit_i || hit_n);
    end

endmodule

// File: tb/tb_endgame_banner.sv
// Randomized bench for endgame_banner: two instances (2 and 9 players) share
// stimulus; a frame-level reference model predicts outputs into a scoreboard
// that a separate monitor drains and compares every cycle.
module tb_endgame_banner;

    localparam int CP    = 31;
    localparam int STEP  = 4;
    localparam int BLINK = 2;
    localparam int HOLD  = 7;
    localparam int NCYC  = 20000;

    localparam int P_IDLE  = 0;
    localparam int P_SLIDE = 1;
    localparam int P_SHOW  = 2;
    localparam int P_WAIT  = 3;

    logic       clk = 1'b0;
    logic       reset, frame_tick, game_over, restart_btn;
    logic [3:0] who_win;
    logic [9:0] start_x, start_y, x, y;
    logic [1:0] dp, dw, ba, rr;

    always #5 clk = ~clk;

    endgame_banner #(.N_PLAYERS(2), .CHAR_PITCH(CP), .SLIDE_STEP(STEP),
                     .BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD)) u_two (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
        .who_win(who_win), .restart_btn(restart_btn), .start_x(start_x),
        .start_y(start_y), .x(x), .y(y), .display_player(dp[0]),
        .display_win(dw[0]), .banner_active(ba[0]), .restart_req(rr[0]));

    endgame_banner #(.N_PLAYERS(9), .CHAR_PITCH(CP), .SLIDE_STEP(STEP),
                     .BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD)) u_nine (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
        .who_win(who_win), .restart_btn(restart_btn), .start_x(start_x),
        .start_y(start_y), .x(x), .y(y), .display_player(dp[1]),
        .display_win(dw[1]), .banner_active(ba[1]), .restart_req(rr[1]));

    // Glyph pictures, row 0 on top, bit 4 leftmost
    bit [4:0] pic_p[7], pic_w[7], pic_i[7], pic_n[7];
    bit [4:0] pic_d[10][7];

    // Reference model state per instance
    int m_phase[2], m_pos[2], m_win[2], m_ticks[2];
    bit m_req[2];

    bit [7:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int n_players(int i);
        return (i == 0) ? 2 : 9;
    endfunction

    function automatic int clamp10(int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic void model_step(int i);
        m_req[i] = 1'b0;
        if (reset) begin
            m_phase[i] = P_IDLE; m_pos[i] = 0; m_win[i] = 1; m_ticks[i] = 0;
        end else begin
            case (m_phase[i])
                P_IDLE: if (game_over) begin
                    m_win[i]   = (who_win >= 1 && int'(who_win) <= n_players(i)) ? int'(who_win) : 1;
                    m_pos[i]   = 0;
                    m_phase[i] = P_SLIDE;
                end
                P_SLIDE: if (frame_tick) begin
                    m_pos[i] = m_pos[i] + STEP;
                    if (m_pos[i] >= int'(start_y)) begin
                        m_pos[i] = int'(start_y); m_phase[i] = P_SHOW; m_ticks[i] = 0;
                    end
                end
                P_SHOW: if (frame_tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == HOLD) m_phase[i] = P_WAIT;
                end
                default: if (restart_btn) begin
                    m_req[i] = 1'b1; m_phase[i] = P_IDLE;
                end
            endcase
        end
    endfunction

    // g: 0=P 1=digit 2=W 3=I 4=N; banner slots are 0,1,3,4,5
    function automatic bit pix(int g, int digit, int top);
        int slot, gx, dx, dy;
        bit [4:0] row;
        slot = (g < 2) ? g : g + 1;
        gx = int'(start_x) + slot * CP;
        dx = int'(x) - gx;
        dy = int'(y) - top;
        if (dx < 0 || dx >= 20 || dy < 0 || dy >= 28) return 1'b0;
        case (g)
            0:       row = pic_p[dy / 4];
            1:       row = pic_d[digit][dy / 4];
            2:       row = pic_w[dy / 4];
            3:       row = pic_i[dy / 4];
            default: row = pic_n[dy / 4];
        endcase
        return row[4 - dx / 4];
    endfunction

    // Expected {display_player, display_win, banner_active, restart_req}
    function automatic bit [3:0] expect_out(int i);
        bit act, vis, pl, wn;
        act = (m_phase[i] != P_IDLE);
        vis = (m_phase[i] != P_SHOW) || (((m_ticks[i] / BLINK) % 2) == 0);
        pl  = pix(0, m_win[i], m_pos[i]) || pix(1, m_win[i], m_pos[i]);
        wn  = pix(2, 0, m_pos[i]) || pix(3, 0, m_pos[i]) || pix(4, 0, m_pos[i]);
        return {act && pl, act && vis && wn, act, m_req[i]};
    endfunction

    task automatic check(input string name, input int inst, input logic act, input bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s[N=%0d] t=%0t x=%0d y=%0d got %b want %b",
                         name, n_players(inst), $time, x, y, act, exp);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare away from the edge
    initial begin
        bit [7:0] e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 2; i++) begin
                    check("display_player", i, dp[i], e[4*i+3]);
                    check("display_win",    i, dw[i], e[4*i+2]);
                    check("banner_active",  i, ba[i], e[4*i+1]);
                    check("restart_req",    i, rr[i], e[4*i+0]);
                end
            end
        end
    end

    // Driver: advance the model with the inputs just sampled, then apply new ones
    initial begin
        pic_p = '{5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
        pic_w = '{5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
        pic_i = '{5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
        pic_n = '{5'b10001, 5'b11001, 5'b11001, 5'b10101, 5'b10011, 5'b10011, 5'b10001};
        pic_d[0] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        pic_d[1] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
        pic_d[2] = '{5'b11111, 5'b00001, 5'b00001, 5'b11111, 5'b10000, 5'b10000, 5'b11111};
        pic_d[3] = '{5'b11111, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00001, 5'b11111};
        pic_d[4] = '{5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001, 5'b00001};
        pic_d[5] = '{5'b11111, 5'b10000, 5'b10000, 5'b11111, 5'b00001, 5'b00001, 5'b11111};
        pic_d[6] = '{5'b11111, 5'b10000, 5'b10000, 5'b11111, 5'b10001, 5'b10001, 5'b11111};
        pic_d[7] = '{5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
        pic_d[8] = '{5'b11111, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b11111};
        pic_d[9] = '{5'b11111, 5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001, 5'b11111};

        reset = 1'b1; frame_tick = 1'b0; game_over = 1'b1; restart_btn = 1'b0;
        who_win = 4'd2; start_x = 10'd100; start_y = 10'd100; x = 10'd0; y = 10'd0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) model_step(i);

            reset      = (cyc < 4) || ($urandom_range(0, 499) == 0);
            game_over  = (cyc < 4) || ($urandom_range(0, 9) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            who_win    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 6) == 0) restart_btn = 1'($urandom_range(0, 1));
            if (m_phase[0] == P_IDLE && $urandom_range(0, 3) == 0) begin
                start_x = 10'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023)
                                                          : $urandom_range(0, 840));
                start_y = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 12)
                                                          : $urandom_range(0, 160));
            end else if (m_phase[0] == P_SLIDE && $urandom_range(0, 40) == 0) begin
                start_y = 10'($urandom_range(0, 160));
            end else if ($urandom_range(0, 60) == 0) begin
                start_x = 10'($urandom_range(0, 840));
            end
            x = 10'(clamp10(int'(start_x) + int'($urandom_range(0, 200)) - 8));
            y = 10'(clamp10(m_pos[0] + int'($urandom_range(0, 36)) - 4));

            sb.push_back({expect_out(1), expect_out(0)});
        end

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/endgame_banner.md
# endgame_banner

Animated, parametrised end-of-game banner for the VGA pong display. On a game-over pulse it latches the winner and slides the "P<n> WIN" banner down from the top of the screen. Once at its final position the "WIN" text blinks for a fixed number of frames, then stays solid while the block waits for a restart press. It sits between the game-state controller and the pixel mixer, beside the score and paddle renderers, and drives the same per-pixel `display_player` / `display_win` enables the mixer already consumes.

## Interface
- `N_PLAYERS`, 2: number of players; legal range 2..9 (single seven-segment digit).
- `CHAR_PITCH`, 31: horizontal glyph pitch in pixels.
- `SLIDE_STEP`, 4: pixels moved down per frame during the slide.
- `BLINK_FRAMES`, 30: frames per blink half-period.
- `HOLD_FRAMES`, 300: frames in SHOW before entering WAIT; must be ≥1.

Ports:
- `clk` input 1: pixel clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse per frame, at vsync.
- `game_over` input 1: one-cycle pulse from the game controller.
- `who_win` input 4: winning player number, sampled on `game_over`.
- `restart_btn` input 1: debounced level.
- `start_x` input 10: banner left edge.
- `start_y` input 10: final banner top edge.
- `x` input 10: current pixel column.
- `y` input 10: current pixel row.
- `display_player` output 1: pixel is part of "P<n>".
- `display_win` output 1: pixel is part of "WIN".
- `banner_active` output 1: high in every state except IDLE.
- `restart_req` output 1: one-cycle pulse requesting a new game.

## Operation
- FSM states: IDLE, SLIDE, SHOW, WAIT. All state is in registers.
- **IDLE**
  - `game_over`=1: latch the winner, set `cur_y`=0 and go to SLIDE.
  - Winner latch: `who_win` in 1..N_PLAYERS is stored as is. Any other value, including 0, is stored as 1.
- **SLIDE**
  - On each `frame_tick`, compute `nxt = cur_y + SLIDE_STEP` in 11 bits, so there is no wrap.
  - If `nxt ≥ start_y`: set `cur_y = start_y`, go to SHOW.
  - Otherwise: set `cur_y = nxt`.
  - If `start_y` is 0, SHOW is entered on the first tick.
- **SHOW**
  - Entry clears `blink_cnt` and `hold_cnt` and sets `visible`=1.
  - Each `frame_tick` increments both counters.
  - When `blink_cnt` reaches BLINK_FRAMES: toggle `visible`, clear `blink_cnt`.
  - When `hold_cnt` reaches HOLD_FRAMES: go to WAIT.
- **WAIT**
  - `visible` is forced to 1.
  - `restart_btn`=1: pulse `restart_req` for one cycle, go to IDLE.
- `restart_btn` is ignored outside WAIT.
- `game_over` is ignored outside IDLE.
- **Rendering** is combinational from `x`, `y` and registered state, using the existing glyph renderers at top edge `cur_y`:
  - P at `start_x`.
  - Winner digit (seven-segment pattern of the latched number) at `start_x+CHAR_PITCH`.
  - W at `start_x+3·CHAR_PITCH`.
  - I at `start_x+4·CHAR_PITCH`.
  - N at `start_x+5·CHAR_PITCH`.
  - `display_player` = OR of the P and digit hits, gated by state≠IDLE.
  - `display_win` = OR of the W, I and N hits, gated by state≠IDLE and by `visible`.

## Timing
- **Reset:** state=IDLE, `cur_y`=0, winner=1, counters=0, `visible`=1, `restart_req`=0, `banner_active`=0. Display outputs are therefore 0. Reset takes priority over every event, including mid-SLIDE and mid-SHOW.
- **Start:** `game_over` at cycle n makes `banner_active`=1 from cycle n+1. A `frame_tick` coinciding with `game_over` does not move the banner.
- **Slide length:** SLIDE takes ceil(`start_y`/SLIDE_STEP) ticks, with a minimum of 1.
- **First toggle:** `visible` first toggles on the BLINK_FRAMES-th tick after SHOW entry.
- **SHOW exit:** WAIT is entered in the cycle after the HOLD_FRAMES-th tick.
- **Restart:** `restart_btn` sampled high in WAIT at cycle m gives `restart_req`=1 in cycle m+1 only. In that same cycle state is IDLE and `banner_active`=0.
- **Input changes:** `start_x` / `start_y` changes take effect immediately. Changing `start_y` during SLIDE affects the next comparison only.

## Test plan
- **Reset:** assert `reset`, sweep `x`/`y` over the banner area → all outputs 0. Pulse `game_over` with `reset` held → stays IDLE.
- **Slide:** `game_over`, `who_win`=2, `start_y`=100, SLIDE_STEP=4, 25 ticks → `cur_y` steps 4, 8, …, 100, and SHOW is entered after tick 25. Pixel (`start_x+31`, `y`) checks the digit-2 segments at each `cur_y`.
- **Blink and hold:** BLINK_FRAMES=2, HOLD_FRAMES=7.
  - `display_win` over the W pixel is 1 for 2 ticks, then 0 for 2, then 1 for 2, then 0.
  - WAIT is entered after tick 7 and `display_win` is then solid 1.
- **Restart filtering:** `restart_btn` held during SLIDE/SHOW → no `restart_req`. In WAIT → exactly one pulse, then IDLE, with `display_player`=0.
- **Bad winner:** `who_win`=0 and `who_win`=9 with N_PLAYERS=2 → digit renders as 1. A second `game_over` mid-SHOW → ignored.
- **Reset mid-SLIDE:** `reset` at `cur_y`=40 → IDLE and `banner_active`=0 on the next cycle. A later `game_over` restarts from `cur_y`=0.
